soc_system_pll_reset_ctrl: RTL and testbench

Reset sequencer and lock supervisor for the fabric PLL (50 MHz refclk to 400 MHz outclk). It runs on the PLL reference clock and drives the PLL reset. It qualifies the asynchronous `locked` output with a synchronizer, a stability window and a timeout, retries failed lock attempts, and holds the downstream clock-domain reset until the PLL output is trustworthy. It also detects loss of lock at run time and supports a software-requested relock.

---
 rtl/soc_system_pll_reset_ctrl.sv | 166 ++++++++++++++++
 tb/tb_soc_system_pll_reset_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/soc_system_pll_reset_ctrl.sv
// Fabric PLL reset sequencer and lock supervisor.
// Runs on the PLL reference clock. It qualifies the asynchronous lock
// indicator and holds the PLL-domain reset until lock is trustworthy.
//
// state     | meaning
// ----------+-------------------------------------------------------
// RESET_PLL | PLL reset asserted, counting the hold time
// WAIT_LOCK | PLL released, waiting for synchronized lock
// STABILIZE | lock seen, counting consecutive locked cycles
// RUN       | PLL output qualified, domain reset released
// FAILED    | all attempts exhausted, PLL held in reset until relock/rst
module soc_system_pll_reset_ctrl #(
  parameter int RST_HOLD_CYCLES    = 16,
  parameter int LOCK_TIMEOUT       = 65536,
  parameter int LOCK_STABLE_CYCLES = 256,
  parameter int MAX_RETRIES        = 4,
  parameter int SYNC_STAGES        = 2
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       clk_ready,
  output logic       domain_rst,
  output logic       lock_lost,
  output logic [7:0] retry_count,
  output logic       fail
);

  localparam int HOLD_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
  localparam int TO_W   = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int STB_W  = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [STB_W-1:0]  STB_LAST  = STB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [7:0]        RETRY_MAX = 8'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABILIZE = 3'd2,
    S_RUN       = 3'd3,
    S_FAILED    = 3'd4
  } state_t;

  state_t                   state, state_n;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     locked_s;
  logic [HOLD_W-1:0]        hold_cnt, hold_n;
  logic [TO_W-1:0]          to_cnt, to_n;
  logic [STB_W-1:0]         stb_cnt, stb_n;
  logic [7:0]               retry_n;
  logic                     lost_n;
  logic                     timeout;

  assign locked_s = sync_q[SYNC_STAGES-1];
  assign timeout  = (to_cnt == TO_LAST);

  // Bring the asynchronous lock indicator into the refclk domain.
  always_ff @(posedge refclk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
  end

  // State, counters and outputs; outputs are decoded from the next state
  // so they move on the same edge as the state.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state       <= S_RESET_PLL;
      hold_cnt    <= '0;
      to_cnt      <= '0;
      stb_cnt     <= '0;
      retry_count <= 8'd0;
      pll_rst     <= 1'b1;
      clk_ready   <= 1'b0;
      domain_rst  <= 1'b1;
      lock_lost   <= 1'b0;
      fail        <= 1'b0;
    end else begin
      state       <= state_n;
      hold_cnt    <= hold_n;
      to_cnt      <= to_n;
      stb_cnt     <= stb_n;
      retry_count <= retry_n;
      pll_rst     <= (state_n == S_RESET_PLL) || (state_n == S_FAILED);
      clk_ready   <= (state_n == S_RUN);
      domain_rst  <= (state_n != S_RUN);
      lock_lost   <= lost_n;
      fail        <= (state_n == S_FAILED);
    end
  end

  // Next-state logic; relock beats timeout, and timeout beats stability.
  always_comb begin
    state_n = state;
    hold_n  = hold_cnt;
    to_n    = to_cnt;
    stb_n   = stb_cnt;
    retry_n = retry_count;
    lost_n  = 1'b0;
    if (relock_req) begin
      state_n = S_RESET_PLL;
      hold_n  = '0;
      retry_n = 8'd0;
    end else begin
      case (state)
        S_RESET_PLL: begin
          if (hold_cnt == HOLD_LAST) begin
            state_n = S_WAIT_LOCK;
            hold_n  = '0;
            to_n    = '0;
            stb_n   = '0;
          end else begin
            hold_n = hold_cnt + 1'b1;
          end
        end
        S_WAIT_LOCK, S_STABILIZE: begin
          if (timeout) begin
            hold_n = '0;
            stb_n  = '0;
            if (retry_count < RETRY_MAX) begin
              retry_n = retry_count + 8'd1;
              state_n = S_RESET_PLL;
            end else begin
              state_n = S_FAILED;
            end
          end else begin
            to_n = to_cnt + 1'b1;
            if (state == S_WAIT_LOCK) begin
              if (locked_s) begin
                state_n = S_STABILIZE;
                stb_n   = STB_W'(1);
              end
            end else if (!locked_s) begin
              // Chatter restarts the stability window but not the timeout.
              state_n = S_WAIT_LOCK;
              stb_n   = '0;
            end else if (stb_cnt >= STB_LAST) begin
              state_n = S_RUN;
              retry_n = 8'd0;
            end else begin
              stb_n = stb_cnt + 1'b1;
            end
          end
        end
        S_RUN: begin
          if (!locked_s) begin
            lost_n  = 1'b1;
            state_n = S_RESET_PLL;
            hold_n  = '0;
          end
        end
        S_FAILED: begin
          state_n = S_FAILED;
        end
        default: begin
          state_n = S_RESET_PLL;
          hold_n  = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_soc_system_pll_reset_ctrl.sv
// Directed bench for the PLL reset sequencer with small parameters.
module tb_soc_system_pll_reset_ctrl;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_rst, clk_ready, domain_rst, lock_lost, fail;
  logic [7:0] retry_count;

  int checks = 0;
  int errors = 0;

  soc_system_pll_reset_ctrl #(
    .RST_HOLD_CYCLES(4),
    .LOCK_TIMEOUT(32),
    .LOCK_STABLE_CYCLES(8),
    .MAX_RETRIES(2),
    .SYNC_STAGES(2)
  ) dut (
    .refclk(refclk),
    .rst(rst),
    .pll_locked(pll_locked),
    .relock_req(relock_req),
    .pll_rst(pll_rst),
    .clk_ready(clk_ready),
    .domain_rst(domain_rst),
    .lock_lost(lock_lost),
    .retry_count(retry_count),
    .fail(fail)
  );

  // 50 MHz reference clock.
  always #10 refclk = ~refclk;

  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Checks every output; domain_rst must always mirror ~clk_ready.
  task automatic chk_all(input string tag, input logic pr, input logic cr,
                         input logic ll, input logic [7:0] rc, input logic fl);
    chk({tag, ".pll_rst"},     {7'd0, pll_rst},    {7'd0, pr});
    chk({tag, ".clk_ready"},   {7'd0, clk_ready},  {7'd0, cr});
    chk({tag, ".domain_rst"},  {7'd0, domain_rst}, {7'd0, ~cr});
    chk({tag, ".lock_lost"},   {7'd0, lock_lost},  {7'd0, ll});
    chk({tag, ".retry_count"}, retry_count,        rc);
    chk({tag, ".fail"},        {7'd0, fail},       {7'd0, fl});
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    relock_req = 1'b0;
    repeat (cycles) step();
    chk_all("reset", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    // Nominal lock: pll_locked rises before edge 7 after release.
    pll_locked = 1'b0;
    do_reset(3);
    for (int n = 1; n <= 3; n++) begin
      step();
      chk("nom.hold", {7'd0, pll_rst}, 8'd1);
    end
    step();
    chk_all("nom.release", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    repeat (2) step();
    pll_locked = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      step();
      chk("nom.not_ready", {7'd0, clk_ready}, 8'd0);
    end
    step();
    chk_all("nom.ready", 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);

    // Loss of lock in RUN: one-cycle drop.
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    step();
    chk_all("loss.e2", 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    step();
    chk_all("loss.e3", 1'b1, 1'b0, 1'b1, 8'd0, 1'b0);
    for (int n = 4; n <= 6; n++) begin
      step();
      chk_all("loss.hold", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    end
    step();
    chk_all("loss.release", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    repeat (7) step();
    chk("loss.e14", {7'd0, clk_ready}, 8'd0);
    step();
    chk_all("loss.relocked", 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);

    // Software relock while in RUN.
    relock_req = 1'b1;
    step();
    relock_req = 1'b0;
    chk_all("relock_run.e1", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    step();
    chk_all("relock_run.e2", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);

    // No lock at all: three attempts, then FAILED at edge 108.
    pll_locked = 1'b0;
    do_reset(2);
    for (int n = 1; n <= 108; n++) begin
      step();
      chk_all("nolock", (n == 108) ? 1'b1 : ((n % 36) < 4),
              1'b0, 1'b0, (n == 108) ? 8'd2 : 8'(n / 36), (n >= 108));
    end
    repeat (5) step();
    chk_all("failed.stays", 1'b1, 1'b0, 1'b0, 8'd2, 1'b1);

    // Relock out of FAILED.
    relock_req = 1'b1;
    step();
    relock_req = 1'b0;
    chk_all("relock_fail.e1", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    repeat (3) step();
    chk_all("relock_fail.e4", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    step();
    chk_all("relock_fail.e5", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);

    // Lock chatter: 5 high / 1 low never qualifies; timeout at edge 36.
    pll_locked = 1'b0;
    do_reset(2);
    repeat (4) step();
    chk("chat.release", {7'd0, pll_rst}, 8'd0);
    for (int k = 0; k < 32; k++) begin
      pll_locked = ((k % 6) < 5);
      step();
      chk("chat.ready", {7'd0, clk_ready}, 8'd0);
      chk("chat.pll_rst", {7'd0, pll_rst}, (k == 31) ? 8'd1 : 8'd0);
      chk("chat.retry", retry_count, (k == 31) ? 8'd1 : 8'd0);
    end

    // Relock on the same cycle as a timeout wins: retry stays 0.
    pll_locked = 1'b0;
    do_reset(2);
    repeat (35) step();
    chk_all("relock_to.e35", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    relock_req = 1'b1;
    step();
    relock_req = 1'b0;
    chk_all("relock_to.e36", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    repeat (3) step();
    chk("relock_to.e39", {7'd0, pll_rst}, 8'd1);
    step();
    chk("relock_to.e40", {7'd0, pll_rst}, 8'd0);

    // rst in the middle of STABILIZE (stb_cnt=5 after edge 9).
    pll_locked = 1'b1;
    do_reset(2);
    repeat (9) step();
    chk_all("mid.stab", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    do_reset(1);
    for (int n = 1; n <= 3; n++) begin
      step();
      chk("mid.hold", {7'd0, pll_rst}, 8'd1);
    end
    step();
    chk("mid.release", {7'd0, pll_rst}, 8'd0);
    repeat (7) step();
    chk("mid.e11", {7'd0, clk_ready}, 8'd0);
    step();
    chk_all("mid.ready", 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
